// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bus bundle between the two data-memory requesters (MEM stage "cpu" and UART
// debug engine "dbg"), the arbiter, and the single-port data memory.
//   cpu_*  : cpu request/command in, grant/stall/read-return out
//   dbg_*  : dbg request/command/lock in, grant/read-return/locked out
//   mem_*  : memory command out, mem_rdata in (valid 1 cycle after a read)
// Modports:
//   slave  : arbiter view
//   master : environment view (requesters + memory)
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_locked;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port data memory between the pipeline MEM stage (cpu) and
// the UART debug loader/dumper (dbg). cpu has priority, but a waiting dbg
// request is served after at most MAX_CPU_BURST consecutive cpu grants. dbg
// can lock the port for atomic multi-word bursts; the pipeline is stalled
// whenever it requests and is not granted.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : dmem_port_arbiter_if.slave (cpu_*, dbg_*, mem_* signals)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_CPU_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  dmem_port_arbiter_if.slave  bus
);

  localparam int                CNT_W   = $clog2(MAX_CPU_BURST + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_CPU_BURST);

  typedef enum logic {
    CPU_PRI,
    DBG_LOCKED
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_next;
  logic              cpu_gnt;
  logic              dbg_gnt;

  logic              cpu_rd_pend;
  logic              dbg_rd_pend;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              we_sel;

  // -------------------------------------------------------------------------
  // Next-state / grant logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next  = state;
    starve_next = '0;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;

    unique case (state)
      CPU_PRI: begin
        if (bus.cpu_req && (!bus.dbg_req || (starve_cnt < MAX_CNT))) begin
          cpu_gnt = 1'b1;
          // A cpu grant with dbg waiting implies starve_cnt < MAX_CNT, so the
          // increment saturates naturally at MAX_CNT; dbg idle clears it.
          if (bus.dbg_req) begin
            starve_next = starve_cnt + 1'b1;
          end
        end else if (bus.dbg_req) begin
          dbg_gnt = 1'b1;
          if (bus.dbg_lock) begin
            state_next = DBG_LOCKED;
          end
        end
      end

      DBG_LOCKED: begin
        // cpu is shut out entirely; dbg gets every cycle it asks for, and the
        // cycle that drops the lock is still served.
        dbg_gnt = bus.dbg_req;
        if (!bus.dbg_lock) begin
          state_next = CPU_PRI;
        end
      end

      default: state_next = CPU_PRI;
    endcase
  end

  // -------------------------------------------------------------------------
  // Memory command mux; idle cycles drive zeros so the bus is quiet.
  // -------------------------------------------------------------------------
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    if (cpu_gnt) begin
      addr_sel  = bus.cpu_addr;
      wdata_sel = bus.cpu_wdata;
      we_sel    = bus.cpu_we;
    end else if (dbg_gnt) begin
      addr_sel  = bus.dbg_addr;
      wdata_sel = bus.dbg_wdata;
      we_sel    = bus.dbg_we;
    end
  end

  assign bus.mem_en    = cpu_gnt | dbg_gnt;
  assign bus.mem_we    = we_sel;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.dbg_locked = (state == DBG_LOCKED);

  // -------------------------------------------------------------------------
  // Read return. The memory presents data the cycle after the read strobe, so
  // the returning owner sees mem_rdata directly during its rvalid pulse and a
  // held copy afterwards; the other requester's rdata is untouched.
  // -------------------------------------------------------------------------
  assign bus.cpu_rvalid = cpu_rd_pend;
  assign bus.dbg_rvalid = dbg_rd_pend;
  assign bus.cpu_rdata  = cpu_rd_pend ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rd_pend ? bus.mem_rdata : dbg_rdata_q;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // Clearing the pending flags drops any read that was in flight.
      state       <= CPU_PRI;
      starve_cnt  <= '0;
      cpu_rd_pend <= 1'b0;
      dbg_rd_pend <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state       <= state_next;
      starve_cnt  <= starve_next;
      cpu_rd_pend <= cpu_gnt & ~bus.cpu_we;
      dbg_rd_pend <= dbg_gnt & ~bus.dbg_we;
      if (cpu_rd_pend) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
      if (dbg_rd_pend) begin
        dbg_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter with a behavioural single-port memory.
// Read expectations are queued when a read is issued and checked when the
// matching rvalid pulse appears. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_CPU_BURST (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural memory: synchronous read, data valid the cycle after the strobe.
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      mem[4] <= 32'h0000_CAFE;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] cpu_q [$];
  logic [DATA_W-1:0] dbg_q [$];

  logic [DATA_W-1:0] burst_data [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) check("cpu_unexpected_rvalid", 1, 0);
      else                   check("cpu_rdata_sb", bus.cpu_rdata, cpu_q.pop_front());
    end
    if (bus.dbg_rvalid === 1'b1) begin
      if (dbg_q.size() == 0) check("dbg_unexpected_rvalid", 1, 0);
      else                   check("dbg_rdata_sb", bus.dbg_rdata, dbg_q.pop_front());
    end
    if (bus.cpu_gnt === 1'b1 && bus.dbg_gnt === 1'b1) check("both_gnt", 1, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    burst_data[0] = 32'hA5A5_0001;
    burst_data[1] = 32'h5A5A_0002;
    burst_data[2] = 32'h1234_0003;
    burst_data[3] = 32'hDEAD_0004;

    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_lock  = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_wdata = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    @(negedge clk);
    check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    check("rst_cpu_rdata",  bus.cpu_rdata,  0);
    check("rst_dbg_rdata",  bus.dbg_rdata,  0);
    check("rst_dbg_locked", bus.dbg_locked, 0);
    check("rst_mem_en",     bus.mem_en,     0);
    check("rst_mem_addr",   bus.mem_addr,   0);
    tick();
    rst = 1'b0;

    // ---------------- 1: cpu-only read ----------------
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h10;
    cpu_q.push_back(32'h0000_CAFE);
    @(negedge clk);
    check("t1_cpu_gnt",   bus.cpu_gnt,   1);
    check("t1_cpu_stall", bus.cpu_stall, 0);
    check("t1_dbg_gnt",   bus.dbg_gnt,   0);
    check("t1_mem_en",    bus.mem_en,    1);
    check("t1_mem_we",    bus.mem_we,    0);
    check("t1_mem_addr",  bus.mem_addr,  32'h10);
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("t1_cpu_rvalid", bus.cpu_rvalid, 1);
    check("t1_cpu_rdata",  bus.cpu_rdata,  32'h0000_CAFE);
    check("t1_dbg_rvalid", bus.dbg_rvalid, 0);
    check("t1_mem_en_idle", bus.mem_en, 0);
    tick();
    @(negedge clk);
    check("t1_rvalid_pulse", bus.cpu_rvalid, 0);
    check("t1_rdata_hold",   bus.cpu_rdata,  32'h0000_CAFE);
    tick();

    // ---------------- 2: starvation bound ----------------
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h100;
    bus.cpu_wdata = 32'h1111_1111;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'h40;
    bus.dbg_wdata = 32'h0000_1234;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("t2_cpu_gnt_c%0d", c),   bus.cpu_gnt,   c != 8);
      check($sformatf("t2_dbg_gnt_c%0d", c),   bus.dbg_gnt,   c == 8);
      check($sformatf("t2_cpu_stall_c%0d", c), bus.cpu_stall, c == 8);
      if (c == 8) check("t2_mem_addr_dbg", bus.mem_addr, 32'h40);
      tick();
      if (c == 8) bus.dbg_req = 1'b0;
    end

    // ---------------- 3: locked dbg burst ----------------
    bus.dbg_req   = 1'b1;
    bus.dbg_lock  = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'h0;
    bus.dbg_wdata = burst_data[0];
    n = 0;
    @(negedge clk);
    while (bus.dbg_gnt !== 1'b1 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("t3_cpu_grants_before_dbg", n, 8);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("t3_dbg_gnt_k%0d", k),    bus.dbg_gnt,    1);
      check($sformatf("t3_cpu_gnt_k%0d", k),    bus.cpu_gnt,    0);
      check($sformatf("t3_cpu_stall_k%0d", k),  bus.cpu_stall,  1);
      check($sformatf("t3_mem_addr_k%0d", k),   bus.mem_addr,   4 * k);
      check($sformatf("t3_mem_wdata_k%0d", k),  bus.mem_wdata,  burst_data[k]);
      check($sformatf("t3_dbg_locked_k%0d", k), bus.dbg_locked, k != 0);
      tick();
      if (k < 3) begin
        bus.dbg_addr  = 32'(4 * (k + 1));
        bus.dbg_wdata = burst_data[k + 1];
      end
      if (k == 2) bus.dbg_lock = 1'b0;
      if (k == 3) bus.dbg_req  = 1'b0;
    end
    @(negedge clk);
    check("t3_released_locked", bus.dbg_locked, 0);
    check("t3_released_cpu_gnt", bus.cpu_gnt, 1);
    tick();
    bus.cpu_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.dbg_req  = 1'b1;
      bus.dbg_we   = 1'b0;
      bus.dbg_addr = 32'(4 * k);
      dbg_q.push_back(burst_data[k]);
      @(negedge clk);
      check($sformatf("t3_rb_gnt_k%0d", k), bus.dbg_gnt, 1);
      tick();
    end
    bus.dbg_req = 1'b0;
    tick();
    tick();

    // ---------------- 4: simultaneous requests ----------------
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h10;
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 32'h8;
    cpu_q.push_back(32'h0000_CAFE);
    @(negedge clk);
    check("t4_cpu_gnt",  bus.cpu_gnt,  1);
    check("t4_dbg_gnt",  bus.dbg_gnt,  0);
    check("t4_mem_addr", bus.mem_addr, 32'h10);
    tick();
    bus.cpu_req = 1'b0;
    dbg_q.push_back(burst_data[2]);
    @(negedge clk);
    check("t4_dbg_gnt_after", bus.dbg_gnt,  1);
    check("t4_mem_addr_dbg",  bus.mem_addr, 32'h8);
    tick();
    bus.dbg_req = 1'b0;
    tick();
    tick();

    // ---------------- 5: reset during a dbg read ----------------
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 32'h4;
    @(negedge clk);
    check("t5_dbg_gnt", bus.dbg_gnt, 1);
    rst = 1'b1;
    tick();
    bus.dbg_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t5_dbg_rvalid", bus.dbg_rvalid, 0);
      check("t5_dbg_rdata",  bus.dbg_rdata,  0);
      check("t5_cpu_rdata",  bus.cpu_rdata,  0);
      check("t5_cpu_rvalid", bus.cpu_rvalid, 0);
      check("t5_dbg_locked", bus.dbg_locked, 0);
      tick();
    end
    rst = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b1;
    bus.cpu_addr = 32'h100;
    @(negedge clk);
    check("t5_cpu_gnt_after_rst", bus.cpu_gnt, 1);
    check("t5_no_late_rvalid", bus.dbg_rvalid, 0);

    // ---------------- 6: lock held without requests ----------------
    tick();
    bus.dbg_req   = 1'b1;
    bus.dbg_lock  = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'h20;
    bus.dbg_wdata = 32'h0BAD_F00D;
    n = 0;
    @(negedge clk);
    while (bus.dbg_gnt !== 1'b1 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("t6_cpu_grants_before_dbg", n, 8);
    tick();
    bus.dbg_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t6_mem_en_c%0d", c),     bus.mem_en,     0);
      check($sformatf("t6_cpu_gnt_c%0d", c),    bus.cpu_gnt,    0);
      check($sformatf("t6_cpu_stall_c%0d", c),  bus.cpu_stall,  1);
      check($sformatf("t6_dbg_locked_c%0d", c), bus.dbg_locked, 1);
      tick();
    end
    bus.dbg_lock = 1'b0;
    @(negedge clk);
    check("t6_drop_cycle_cpu_gnt", bus.cpu_gnt, 0);
    tick();
    @(negedge clk);
    check("t6_cpu_gnt_resumed", bus.cpu_gnt,    1);
    check("t6_unlocked",        bus.dbg_locked, 0);
    tick();
    bus.cpu_req = 1'b0;
    tick();
    tick();

    check("cpu_q_drained", cpu_q.size(), 0);
    check("dbg_q_drained", dbg_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
